// File: rtl/interp_phase_seq.sv
// interp_phase_seq: sample FIFO plus phase sequencer feeding a 4-tap polyphase interpolator.
// A window shift (and FIFO pop) happens exactly on cycles where addr_factor == PHASES-1.
module interp_phase_seq #(
    parameter int TAPS       = 4,
    parameter int PHASES     = 25,
    parameter int FIFO_DEPTH = 8,
    parameter int MULT_LAT   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [7:0] addr_factor,
    output logic [7:0] addr_data,
    output logic [7:0] data_source,
    output logic       phase_valid,
    output logic       dout_valid,
    output logic [7:0] dout_phase
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(TAPS + 1);
    localparam logic [7:0] SHIFT = 8'(PHASES - 1);
    localparam logic [7:0] LAST = 8'(PHASES - 2);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, STALL} state_t;

    state_t        state, state_nx;
    logic [7:0]    factor_nx;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nx;
    logic [PW-1:0] prime_cnt;
    logic          push, pop;
    logic [MULT_LAT-1:0] v_pipe;
    logic [7:0]    p_pipe [MULT_LAT];

    assign in_ready    = count != FULL;
    assign push        = in_valid & in_ready;
    // A registered 24 is only ever issued when the FIFO is known non-empty, so it is the pop.
    assign pop         = (state == PRIME || state == RUN) && addr_factor == SHIFT;
    assign count_nx    = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign data_source = mem[rd_ptr];
    assign phase_valid = state == RUN;
    assign dout_valid  = v_pipe[MULT_LAT-1];
    assign dout_phase  = p_pipe[MULT_LAT-1];

    always_comb begin
        state_nx  = state;
        factor_nx = addr_factor;
        case (state)
            IDLE: begin
                factor_nx = 8'd0;
                if (en && count != 0) begin
                    state_nx  = PRIME;
                    factor_nx = SHIFT;
                end
            end
            PRIME: begin
                if (pop && prime_cnt == PW'(TAPS - 1)) begin
                    state_nx  = RUN;
                    factor_nx = 8'd0;
                end else begin
                    factor_nx = (count_nx != 0) ? SHIFT : 8'd0;
                end
            end
            RUN: begin
                if (addr_factor == SHIFT)
                    factor_nx = 8'd0;
                else if (addr_factor == LAST) begin
                    if (count != 0) factor_nx = SHIFT;
                    else state_nx = STALL;
                end else
                    factor_nx = addr_factor + 8'd1;
            end
            STALL: begin
                if (count != 0) begin
                    state_nx  = RUN;
                    factor_nx = SHIFT;
                end
            end
            default: begin
                state_nx  = IDLE;
                factor_nx = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_factor <= 8'd0;
            addr_data   <= 8'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            prime_cnt   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
        end else if (clr) begin
            state       <= IDLE;
            addr_factor <= 8'd0;
            addr_data   <= 8'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            prime_cnt   <= '0;
        end else begin
            state       <= state_nx;
            addr_factor <= factor_nx;
            count       <= count_nx;
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                addr_data <= addr_data + 8'd1;
            end
            if (state == IDLE) prime_cnt <= '0;
            else if (state == PRIME && pop) prime_cnt <= prime_cnt + 1'b1;
        end
    end

    // Delay line tracks the multiplier; clr does not flush it so in-flight outputs drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_pipe <= '0;
            for (int i = 0; i < MULT_LAT; i++) p_pipe[i] <= 8'd0;
        end else begin
            v_pipe[0] <= phase_valid;
            p_pipe[0] <= addr_factor;
            for (int i = 1; i < MULT_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                p_pipe[i] <= p_pipe[i-1];
            end
        end
    end
endmodule

// File: tb/tb_interp_phase_seq.sv
// tb_interp_phase_seq: directed stimulus with scoreboards for output phases and FIFO pops.
module tb_interp_phase_seq;
    logic       clk = 1'b0;
    logic       rst_n, clr, en, in_valid, in_ready;
    logic [7:0] in_data, addr_factor, addr_data, data_source, dout_phase;
    logic       phase_valid, dout_valid;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] n;
    } pop_t;

    logic [7:0] ph_q[$];
    pop_t       pop_q[$];
    int         vectors = 0;
    int         errors = 0;
    logic       prev_ok = 1'b0;
    logic       prev_pv;
    logic [7:0] prev_af;

    interp_phase_seq dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .addr_factor(addr_factor), .addr_data(addr_data), .data_source(data_source),
        .phase_valid(phase_valid), .dout_valid(dout_valid), .dout_phase(dout_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_af(input logic [7:0] f, input logic v, input int lim);
        int n = 0;
        while (!(addr_factor == f && phase_valid == v) && n < lim) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= lim) begin
            errors++;
            $display("FAIL wait_af: addr_factor %0d phase_valid %0d not reached, stuck at %0d", f, v, addr_factor);
        end
    endtask

    task automatic exp_run(input int last);
        for (int i = 0; i <= last; i++) ph_q.push_back(8'(i));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid) begin
                vectors++;
                if (ph_q.size() == 0) begin
                    errors++;
                    $display("FAIL dout_phase: got %0d with no phase expected", dout_phase);
                end else begin
                    logic [7:0] e;
                    e = ph_q.pop_front();
                    if (dout_phase !== e) begin
                        errors++;
                        $display("FAIL dout_phase: got %0d expected %0d", dout_phase, e);
                    end
                end
            end
            if (addr_factor == 8'd24) begin
                vectors++;
                if (pop_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop: unexpected pop data_source %0d", data_source);
                end else begin
                    pop_t e;
                    e = pop_q.pop_front();
                    if (data_source !== e.d || addr_data !== e.n) begin
                        errors++;
                        $display("FAIL pop: got data %0d addr_data %0d expected data %0d addr_data %0d",
                                 data_source, addr_data, e.d, e.n);
                    end
                end
            end
            if (prev_ok) begin
                vectors++;
                if (dout_valid !== prev_pv || dout_phase !== prev_af) begin
                    errors++;
                    $display("FAIL lag: got valid %0d phase %0d expected valid %0d phase %0d",
                             dout_valid, dout_phase, prev_pv, prev_af);
                end
            end
            prev_pv = phase_valid;
            prev_af = addr_factor;
            prev_ok = 1'b1;
        end else begin
            prev_ok = 1'b0;
        end
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; en = 1'b0; in_valid = 1'b1; in_data = 8'd99;
        repeat (3) @(negedge clk);
        chk("rst_addr_factor", addr_factor, 0);
        chk("rst_addr_data", addr_data, 0);
        chk("rst_data_source", data_source, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_phase_valid", phase_valid, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_phase", dout_phase, 0);
        chk("rst_count", dut.count, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);

        // Prime with four samples, then run out of data and stall at 23.
        for (int i = 0; i < 4; i++) pop_q.push_back({8'(10 * (i + 1)), 8'(i)});
        exp_run(23);
        en = 1'b1;
        push(8'd10); push(8'd20); push(8'd30); push(8'd40);
        wait_af(8'd23, 1'b0, 100);
        repeat (4) begin
            @(negedge clk);
            chk("stall_af", addr_factor, 23);
            chk("stall_pv", phase_valid, 0);
        end
        pop_q.push_back({8'd55, 8'd4});
        ph_q.push_back(8'd24);
        exp_run(23);
        push(8'd55);
        chk("stall_hold_after_push", addr_factor, 23);
        @(negedge clk);
        chk("resume_af", addr_factor, 24);
        chk("resume_pv", phase_valid, 1);
        chk("resume_data", data_source, 55);

        // Steady state: one sample per 25 cycles, crossing addr_data wrap.
        for (int k = 0; k < 252; k++) begin
            pop_q.push_back({8'(k * 37 + 5), 8'(5 + k)});
            ph_q.push_back(8'd24);
            exp_run(k == 251 ? 12 : 23);
            wait_af(8'd22, 1'b1, 60);
            push(8'(k * 37 + 5));
        end

        // Clear mid-run with three samples buffered.
        wait_af(8'd5, 1'b1, 60);
        push(8'd200); push(8'd201); push(8'd202);
        wait_af(8'd12, 1'b1, 60);
        en = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_af", addr_factor, 0);
        chk("clr_pv", phase_valid, 0);
        chk("clr_addr_data", addr_data, 0);
        chk("clr_count", dut.count, 0);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_dout_inflight", dout_valid, 1);
        @(negedge clk);
        chk("clr_dout_drained", dout_valid, 0);

        // Fill the FIFO while idle.
        for (int i = 1; i <= 8; i++) push(8'(i));
        chk("full_in_ready", in_ready, 0);
        chk("full_count", dut.count, 8);
        in_valid = 1'b1; in_data = 8'd9;
        repeat (2) @(negedge clk);
        chk("full_drop_count", dut.count, 8);
        chk("full_drop_ready", in_ready, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        chk("full_clr_count", dut.count, 0);
        chk("full_clr_ready", in_ready, 1);
        push(8'd77);
        chk("resume_push_count", dut.count, 1);
        chk("resume_push_data", data_source, 77);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // Async reset in the middle of a run.
        for (int i = 0; i < 4; i++) pop_q.push_back({8'(11 * (i + 1)), 8'(i)});
        exp_run(9);
        en = 1'b1;
        push(8'd11); push(8'd22); push(8'd33); push(8'd44);
        wait_af(8'd10, 1'b1, 60);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_af", addr_factor, 0);
        chk("arst_pv", phase_valid, 0);
        chk("arst_dout_valid", dout_valid, 0);
        chk("arst_dout_phase", dout_phase, 0);
        chk("arst_addr_data", addr_data, 0);
        chk("arst_data_source", data_source, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_count", dut.count, 0);
        en = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("phase_queue_empty", ph_q.size(), 0);
        chk("pop_queue_empty", pop_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
